kmeans_scheduler: RTL and testbench

Top-level iteration controller for the K-means engine. Validates the cluster count against the core-enable mask from the enable decoder and loads one initial centroid into each enabled distance core. It then runs assignment passes over the point memory, triggering a centroid update after each pass, until no point changes cluster or the iteration budget is exhausted.

---
 rtl/kmeans_scheduler.sv | 277 +++++++++++++++++++++++++++
 tb/tb_kmeans_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_scheduler.sv
// Iteration controller for the K-means engine: validates the run configuration,
// loads initial centroids, then alternates assignment passes and centroid updates.
module kmeans_scheduler #(
    parameter int NCORES = 16,
    parameter int PW     = 16,
    parameter int IW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        k,
    input  logic [PW-1:0]     num_points,
    input  logic [IW-1:0]     max_iter,
    input  logic [NCORES-1:0] core_en,
    output logic              cent_load_valid,
    output logic [3:0]        cent_load_sel,
    output logic [3:0]        cent_load_idx,
    input  logic              cent_load_ready,
    output logic              pt_valid,
    output logic [PW-1:0]     pt_addr,
    input  logic              pt_ready,
    input  logic [NCORES-1:0] core_done,
    output logic              assign_commit,
    input  logic              point_changed,
    output logic              upd_start,
    input  logic              upd_done,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [IW-1:0]     iter_count,
    output logic              error
);

    localparam int SW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT     = 4'd1,
        S_PT_REQ   = 4'd2,
        S_PT_WAIT  = 4'd3,
        S_COMMIT   = 4'd4,
        S_UPD_REQ  = 4'd5,
        S_UPD_WAIT = 4'd6,
        S_CHECK    = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        k_q, k_d;
    logic [PW-1:0]     np_q, np_d;
    logic [IW-1:0]     max_iter_q, max_iter_d;
    logic [NCORES-1:0] en_q, en_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [4:0]        load_cnt_q, load_cnt_d;
    logic [PW-1:0]     pt_addr_q, pt_addr_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic              converged_q, converged_d;
    logic              any_changed_q, any_changed_d;
    logic              error_q, error_d;

    logic              cfg_bad_s;
    logic              start_ok_s;
    logic              scan_en_s;
    logic              load_last_s;
    logic              all_done_s;
    logic              last_pt_s;

    function automatic logic [4:0] popcount(input logic [NCORES-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < NCORES; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Configuration screening and per-state conditions
    always_comb begin
        cfg_bad_s   = (k == 5'd0) || (k > 5'(NCORES)) || (num_points == '0) ||
                      (max_iter == '0) || (popcount(core_en) != k);
        start_ok_s  = start && !abort && !cfg_bad_s;
        scan_en_s   = en_q[scan_q];
        load_last_s = ((load_cnt_q + 5'd1) == k_q);
        all_done_s  = ((core_done & en_q) == en_q);
        last_pt_s   = (pt_addr_q == (np_q - PW'(1)));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok_s) state_d = S_INIT;
                else            state_d = S_IDLE;
            end
            S_INIT: begin
                if (scan_en_s && cent_load_ready && load_last_s) state_d = S_PT_REQ;
                else                                             state_d = S_INIT;
            end
            S_PT_REQ: begin
                if (pt_ready) state_d = S_PT_WAIT;
                else          state_d = S_PT_REQ;
            end
            S_PT_WAIT: begin
                if (all_done_s) state_d = S_COMMIT;
                else            state_d = S_PT_WAIT;
            end
            S_COMMIT: begin
                if (last_pt_s) state_d = S_UPD_REQ;
                else           state_d = S_PT_REQ;
            end
            S_UPD_REQ:  state_d = S_UPD_WAIT;
            S_UPD_WAIT: begin
                if (upd_done) state_d = S_CHECK;
                else          state_d = S_UPD_WAIT;
            end
            S_CHECK: begin
                if (!any_changed_q || (iter_q == max_iter_q)) state_d = S_DONE;
                else                                          state_d = S_PT_REQ;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q           <= 5'd0;
            np_q          <= '0;
            max_iter_q    <= '0;
            en_q          <= '0;
            scan_q        <= '0;
            load_cnt_q    <= 5'd0;
            pt_addr_q     <= '0;
            iter_q        <= '0;
            converged_q   <= 1'b0;
            any_changed_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            k_q           <= k_d;
            np_q          <= np_d;
            max_iter_q    <= max_iter_d;
            en_q          <= en_d;
            scan_q        <= scan_d;
            load_cnt_q    <= load_cnt_d;
            pt_addr_q     <= pt_addr_d;
            iter_q        <= iter_d;
            converged_q   <= converged_d;
            any_changed_q <= any_changed_d;
            error_q       <= error_d;
        end
    end

    // Datapath next values
    always_comb begin
        k_d           = k_q;
        np_d          = np_q;
        max_iter_d    = max_iter_q;
        en_d          = en_q;
        scan_d        = scan_q;
        load_cnt_d    = load_cnt_q;
        pt_addr_d     = pt_addr_q;
        iter_d        = iter_q;
        converged_d   = converged_q;
        any_changed_d = any_changed_q;
        error_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_bad_s) begin
                        error_d = 1'b1;
                    end else begin
                        k_d           = k;
                        np_d          = num_points;
                        max_iter_d    = max_iter;
                        en_d          = core_en;
                        scan_d        = '0;
                        load_cnt_d    = 5'd0;
                        pt_addr_d     = '0;
                        iter_d        = '0;
                        converged_d   = 1'b0;
                        any_changed_d = 1'b0;
                    end
                end else begin
                    error_d = 1'b0;
                end
            end
            S_INIT: begin
                // Disabled cores are skipped at one per cycle; enabled ones wait for ready
                if (!scan_en_s) begin
                    scan_d = scan_q + SW'(1);
                end else if (cent_load_ready) begin
                    scan_d     = scan_q + SW'(1);
                    load_cnt_d = load_cnt_q + 5'd1;
                end else begin
                    scan_d = scan_q;
                end
            end
            S_COMMIT: begin
                any_changed_d = any_changed_q | point_changed;
                if (!last_pt_s) pt_addr_d = pt_addr_q + PW'(1);
                else            pt_addr_d = pt_addr_q;
            end
            S_UPD_WAIT: begin
                if (upd_done) iter_d = iter_q + IW'(1);
                else          iter_d = iter_q;
            end
            S_CHECK: begin
                if (!any_changed_q) begin
                    converged_d = 1'b1;
                end else if (iter_q == max_iter_q) begin
                    converged_d = 1'b0;
                end else begin
                    any_changed_d = 1'b0;
                    pt_addr_d     = '0;
                end
            end
            default: begin
                error_d = 1'b0;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            converged_d = 1'b0;
        end else begin
            converged_d = converged_d;
        end
    end

    // Output decode
    always_comb begin
        cent_load_valid = 1'b0;
        cent_load_sel   = 4'd0;
        cent_load_idx   = 4'd0;
        pt_valid        = 1'b0;
        assign_commit   = 1'b0;
        upd_start       = 1'b0;
        done            = 1'b0;
        busy            = (state_q != S_IDLE);
        pt_addr         = pt_addr_q;
        iter_count      = iter_q;
        converged       = converged_q;
        error           = error_q;
        case (state_q)
            S_INIT: begin
                if (scan_en_s) begin
                    cent_load_valid = 1'b1;
                    cent_load_sel   = 4'(scan_q);
                    cent_load_idx   = load_cnt_q[3:0];
                end else begin
                    cent_load_valid = 1'b0;
                end
            end
            S_PT_REQ:  pt_valid      = 1'b1;
            S_COMMIT:  assign_commit = 1'b1;
            S_UPD_REQ: upd_start     = 1'b1;
            S_DONE:    done          = 1'b1;
            default:   done          = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_kmeans_scheduler.sv
// Directed bench for kmeans_scheduler: configuration checks, full runs,
// handshake stalls, abort and mid-run reset.
module tb_kmeans_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  k;
    logic [15:0] num_points;
    logic [7:0]  max_iter;
    logic [15:0] core_en;
    logic        cent_load_valid;
    logic [3:0]  cent_load_sel;
    logic [3:0]  cent_load_idx;
    logic        cent_load_ready;
    logic        pt_valid;
    logic [15:0] pt_addr;
    logic        pt_ready;
    logic [15:0] core_done;
    logic        assign_commit;
    logic        point_changed;
    logic        upd_start;
    logic        upd_done;
    logic        busy;
    logic        done;
    logic        converged;
    logic [7:0]  iter_count;
    logic        error;

    int errors = 0;
    int checks = 0;

    logic       mon_clr;
    int         n_commit, n_upd, n_done, n_err, n_clv, ld_n;
    logic [3:0] ld_sel [16];
    logic [3:0] ld_idx [16];
    logic [3:0] exp_sel [4];

    kmeans_scheduler #(.NCORES(16), .PW(16), .IW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k(k),
        .num_points(num_points), .max_iter(max_iter), .core_en(core_en),
        .cent_load_valid(cent_load_valid), .cent_load_sel(cent_load_sel),
        .cent_load_idx(cent_load_idx), .cent_load_ready(cent_load_ready),
        .pt_valid(pt_valid), .pt_addr(pt_addr), .pt_ready(pt_ready),
        .core_done(core_done), .assign_commit(assign_commit),
        .point_changed(point_changed), .upd_start(upd_start), .upd_done(upd_done),
        .busy(busy), .done(done), .converged(converged), .iter_count(iter_count),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (mon_clr) begin
            n_commit <= 0; n_upd <= 0; n_done <= 0; n_err <= 0; n_clv <= 0; ld_n <= 0;
        end else begin
            if (assign_commit) n_commit <= n_commit + 1;
            if (upd_start)     n_upd    <= n_upd + 1;
            if (done)          n_done   <= n_done + 1;
            if (error)         n_err    <= n_err + 1;
            if (cent_load_valid) n_clv  <= n_clv + 1;
            if (cent_load_valid && cent_load_ready) begin
                if (ld_n < 16) begin
                    ld_sel[ld_n] <= cent_load_sel;
                    ld_idx[ld_n] <= cent_load_idx;
                end
                ld_n <= ld_n + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        chk(tag, done, 1'b1);
    endtask

    task automatic wait_upd(input string tag, input int budget);
        for (int i = 0; i < budget && !upd_start; i++) tick();
        chk(tag, upd_start, 1'b1);
    endtask

    task automatic wait_ptv(input string tag, input int budget);
        for (int i = 0; i < budget && !pt_valid; i++) tick();
        chk(tag, pt_valid, 1'b1);
    endtask

    task automatic chk_loads(input string tag);
        chk({tag, "_count"}, 64'(ld_n), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_sel"}, 64'(ld_sel[i]), 64'(exp_sel[i]));
            chk({tag, "_idx"}, 64'(ld_idx[i]), 64'(i));
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({cent_load_valid, cent_load_sel, cent_load_idx, pt_valid, pt_addr,
                    assign_commit, upd_start, busy, done, converged, iter_count, error});
    endfunction

    initial begin
        exp_sel[0] = 4'd0; exp_sel[1] = 4'd5; exp_sel[2] = 4'd10; exp_sel[3] = 4'd15;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mon_clr = 1'b1;
        k = 5'd4; num_points = 16'd3; max_iter = 8'd5; core_en = 16'h8421;
        cent_load_ready = 1'b1; pt_ready = 1'b1; core_done = 16'hFFFF;
        point_changed = 1'b1; upd_done = 1'b1;
        tick(); tick();
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", all_outs(), 64'd0);

        // Run 1: changes on iteration 1 only
        clear_mon();
        pulse_start();
        chk("busy_after_start", busy, 1'b1);
        wait_upd("run1_first_upd", 200);
        point_changed = 1'b0;
        wait_done("run1_done", 200);
        chk("run1_converged", converged, 1'b1);
        chk("run1_iter", iter_count, 8'd2);
        chk("run1_commits", 64'(n_commit), 64'd6);
        chk("run1_upds", 64'(n_upd), 64'd2);
        chk_loads("run1_load");
        tick();
        chk("run1_busy_low", busy, 1'b0);
        chk("run1_done_pulse", 64'(n_done), 64'd1);

        // Run 2: every point changes, budget exhausted
        point_changed = 1'b1;
        clear_mon();
        pulse_start();
        wait_done("run2_done", 400);
        chk("run2_converged", converged, 1'b0);
        chk("run2_iter", iter_count, 8'd5);
        chk("run2_commits", 64'(n_commit), 64'd15);
        chk("run2_upds", 64'(n_upd), 64'd5);
        tick();

        // Illegal configurations
        clear_mon();
        k = 5'd5;
        pulse_start();
        chk("err_k5_pulse", error, 1'b1);
        chk("err_k5_busy", busy, 1'b0);
        tick();
        chk("err_k5_one_cycle", error, 1'b0);
        k = 5'd0;
        pulse_start();
        chk("err_k0_pulse", error, 1'b1);
        tick();
        k = 5'd17;
        pulse_start();
        chk("err_k17_pulse", error, 1'b1);
        tick();
        k = 5'd4; num_points = 16'd0;
        pulse_start();
        chk("err_np0_pulse", error, 1'b1);
        chk("err_np0_busy", busy, 1'b0);
        tick(); tick();
        chk("err_count", 64'(n_err), 64'd4);
        chk("err_no_load", 64'(n_clv), 64'd0);
        chk("err_converged_held", converged, 1'b0);
        chk("err_iter_held", iter_count, 8'd5);

        // Stalled handshakes and a slow enabled core
        num_points = 16'd2; max_iter = 8'd1; point_changed = 1'b0;
        cent_load_ready = 1'b0; pt_ready = 1'b0; core_done = 16'h0000;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("stall_clv", cent_load_valid, 1'b1);
            chk("stall_sel", cent_load_sel, 4'd0);
            chk("stall_idx", cent_load_idx, 4'd0);
            tick();
        end
        cent_load_ready = 1'b1;
        wait_ptv("stall_ptv", 100);
        for (int i = 0; i < 4; i++) begin
            chk("stall_pt_valid", pt_valid, 1'b1);
            chk("stall_pt_addr", pt_addr, 16'd0);
            tick();
        end
        pt_ready = 1'b1;
        core_done = 16'h8021 | (16'($urandom) & 16'h7BDE);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("stall_no_commit", assign_commit, 1'b0);
            core_done = 16'h8021 | (16'($urandom) & 16'h7BDE);
            tick();
        end
        chk("stall_still_waiting", assign_commit, 1'b0);
        core_done = 16'hFFFF;
        tick();
        chk("stall_commit", assign_commit, 1'b1);
        chk("stall_commit_addr", pt_addr, 16'd0);
        wait_done("stall_done", 100);
        chk("stall_converged", converged, 1'b1);
        chk("stall_iter", iter_count, 8'd1);
        chk("stall_commits", 64'(n_commit), 64'd2);
        chk_loads("stall_load");
        tick();

        // Abort in UPD_WAIT of iteration 2
        num_points = 16'd3; max_iter = 8'd5; point_changed = 1'b1; upd_done = 1'b0;
        clear_mon();
        pulse_start();
        wait_upd("abort_upd1", 200);
        tick();
        chk("abort_iter0", iter_count, 8'd0);
        upd_done = 1'b1;
        tick();
        upd_done = 1'b0;
        chk("abort_iter1", iter_count, 8'd1);
        wait_upd("abort_upd2", 200);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_converged", converged, 1'b0);
        chk("abort_iter", iter_count, 8'd1);
        chk("abort_upd_start", upd_start, 1'b0);
        tick(); tick();
        chk("abort_no_done", 64'(n_done), 64'd0);

        // Clean restart after abort
        upd_done = 1'b1; point_changed = 1'b0;
        clear_mon();
        pulse_start();
        chk("restart_init", cent_load_valid, 1'b1);
        wait_done("restart_done", 200);
        chk("restart_converged", converged, 1'b1);
        chk("restart_iter", iter_count, 8'd1);
        chk_loads("restart_load");
        tick();

        // Start ignored while busy, then reset mid-assignment
        core_done = 16'h0000;
        pulse_start();
        wait_ptv("busy_ptv", 100);
        tick();
        pulse_start();
        chk("busy_start_ignored_busy", busy, 1'b1);
        chk("busy_start_ignored_clv", cent_load_valid, 1'b0);
        chk("busy_start_ignored_ptv", pt_valid, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("midrun_reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        core_done = 16'hFFFF;
        tick(); tick();
        chk("post_reset_idle", all_outs(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
